// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
// Shared types and widths for the PLL reset sequencer.
//   state_t : sequencer states, 3-bit encoding
//   LOSS_W  : width of the saturating lock-loss counter
//   RETRY_W : width of the failed-attempt counter
// ---------------------------------------------------------------------------
package pll_seq_pkg;

  localparam int LOSS_W  = 8;
  localparam int RETRY_W = 3;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop level synchronizer for a single asynchronous bit.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, clears both flops to 0
//   i_d     : asynchronous level input
//   o_q     : synchronized level, i_d delayed by two i_clk edges
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
// Power-up and recovery controller for the iCE40 PLL. Holds the PLL in reset,
// waits for a synchronized LOCK, qualifies it for LOCK_STABLE_CYCLES, then
// releases the core reset request. Lock loss or lock timeout re-sequences the
// PLL; after MAX_RETRIES failed attempts the block parks in FAULT.
//   i_referenceclk  : board reference clock (only clock)
//   i_reset_n       : asynchronous active-low reset
//   i_pll_lock      : raw PLL LOCK, asynchronous
//   i_restart       : single-cycle re-sequence request, also clears FAULT
//   o_pll_resetb    : PLL RESETB, active low
//   o_core_reset_n  : core reset request, high only in RUN
//   o_ready         : high only in RUN
//   o_fault         : high only in FAULT
//   o_retry_count   : failed attempts since last RUN entry / reset / restart
//   o_loss_count    : lock losses seen in RUN, saturating
// ---------------------------------------------------------------------------
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic               i_referenceclk,
  input  logic               i_reset_n,
  input  logic               i_pll_lock,
  input  logic               i_restart,
  output logic               o_pll_resetb,
  output logic               o_core_reset_n,
  output logic               o_ready,
  output logic               o_fault,
  output logic [RETRY_W-1:0] o_retry_count,
  output logic [LOSS_W-1:0]  o_loss_count
);

  // Parameter range checks; any violation stops elaboration.
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("pll_reset_sequencer: CNT_W out of range");
  end
  if (RST_CYCLES < 1 || longint'(RST_CYCLES) > (64'sd1 <<< CNT_W)) begin : g_bad_rst
    $error("pll_reset_sequencer: RST_CYCLES out of range");
  end
  if (LOCK_STABLE_CYCLES < 1 ||
      longint'(LOCK_STABLE_CYCLES) > (64'sd1 <<< CNT_W)) begin : g_bad_stable
    $error("pll_reset_sequencer: LOCK_STABLE_CYCLES out of range");
  end
  if (LOCK_TIMEOUT_CYCLES < 1 ||
      longint'(LOCK_TIMEOUT_CYCLES) > (64'sd1 <<< CNT_W)) begin : g_bad_timeout
    $error("pll_reset_sequencer: LOCK_TIMEOUT_CYCLES out of range");
  end
  if (MAX_RETRIES < 1 || MAX_RETRIES > 7) begin : g_bad_retries
    $error("pll_reset_sequencer: MAX_RETRIES out of range");
  end

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W:0]   RETRY_LIMIT  = (RETRY_W+1)'(MAX_RETRIES);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [RETRY_W-1:0]   r_retry;
  logic [RETRY_W-1:0]   w_retry_next;
  logic [RETRY_W:0]     w_retry_inc;
  logic [LOSS_W-1:0]    r_loss;
  logic [LOSS_W-1:0]    w_loss_next;
  logic                 r_pll_resetb;
  logic                 r_core_reset_n;
  logic                 r_ready;
  logic                 r_fault;
  logic                 w_lock_s;

  sync_2ff u_lock_sync (
    .i_clk   (i_referenceclk),
    .i_rst_n (i_reset_n),
    .i_d     (i_pll_lock),
    .o_q     (w_lock_s)
  );

  // One bit wider than the counter so the limit compare cannot wrap.
  assign w_retry_inc = {1'b0, r_retry} + (RETRY_W+1)'(1);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_retry_next = r_retry;
    w_loss_next  = r_loss;

    if (i_restart) begin
      // Restart overrides every other transition, but keeps the loss history.
      w_state_next = ST_HOLD;
      w_cnt_next   = '0;
      w_retry_next = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == RST_LAST) begin
            w_state_next = ST_WAIT_LOCK;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock is checked first so a lock arriving on the timeout cycle wins.
          if (w_lock_s) begin
            w_state_next = ST_STABLE;
            w_cnt_next   = '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_cnt_next   = '0;
            w_retry_next = w_retry_inc[RETRY_W-1:0];
            w_state_next = (w_retry_inc < RETRY_LIMIT) ? ST_HOLD : ST_FAULT;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end

        ST_STABLE: begin
          // A lock drop restarts the lock wait without consuming a retry.
          if (!w_lock_s) begin
            w_state_next = ST_WAIT_LOCK;
            w_cnt_next   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_next = ST_RUN;
            w_cnt_next   = '0;
            w_retry_next = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          w_cnt_next = '0;
          if (!w_lock_s) begin
            w_state_next = ST_HOLD;
            if (r_loss != '1) begin
              w_loss_next = r_loss + 1'b1;
            end
          end
        end

        ST_FAULT: begin
          w_cnt_next = '0;
        end

        default: begin
          w_state_next = ST_HOLD;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register and carry no decode glitches.
  always_ff @(posedge i_referenceclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= ST_HOLD;
      r_cnt          <= '0;
      r_retry        <= '0;
      r_loss         <= '0;
      r_pll_resetb   <= 1'b0;
      r_core_reset_n <= 1'b0;
      r_ready        <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_retry        <= w_retry_next;
      r_loss         <= w_loss_next;
      r_pll_resetb   <= (w_state_next != ST_HOLD) && (w_state_next != ST_FAULT);
      r_core_reset_n <= (w_state_next == ST_RUN);
      r_ready        <= (w_state_next == ST_RUN);
      r_fault        <= (w_state_next == ST_FAULT);
    end
  end

  assign o_pll_resetb   = r_pll_resetb;
  assign o_core_reset_n = r_core_reset_n;
  assign o_ready        = r_ready;
  assign o_fault        = r_fault;
  assign o_retry_count  = r_retry;
  assign o_loss_count   = r_loss;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Directed bench for pll_reset_sequencer with small timing parameters.
// A per-cycle vector table covers clean start, runtime loss, restart in RUN,
// a lock glitch during qualification, two timeouts into FAULT and restart out
// of FAULT. Hand sequences cover async reset mid-STABLE and lock arriving on
// the exact timeout cycle.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int RST_CYCLES          = 4;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int LOCK_TIMEOUT_CYCLES = 32;
  localparam int MAX_RETRIES         = 2;
  localparam int CNT_W               = 16;
  localparam int NVEC                = 145;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               pll_lock;
  logic               restart;
  logic               pll_resetb;
  logic               core_reset_n;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_count;
  logic [LOSS_W-1:0]  loss_count;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_CYCLES          (RST_CYCLES),
    .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
    .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
    .MAX_RETRIES         (MAX_RETRIES),
    .CNT_W               (CNT_W)
  ) dut (
    .i_referenceclk (clk),
    .i_reset_n      (reset_n),
    .i_pll_lock     (pll_lock),
    .i_restart      (restart),
    .o_pll_resetb   (pll_resetb),
    .o_core_reset_n (core_reset_n),
    .o_ready        (ready),
    .o_fault        (fault),
    .o_retry_count  (retry_count),
    .o_loss_count   (loss_count)
  );

  // exp = {pll_resetb, core_reset_n, ready, fault, retry[2:0], loss[7:0]}
  typedef struct {
    logic        lock;
    logic        restart;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl [1:NVEC];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [14:0] outs_now();
    return {pll_resetb, core_reset_n, ready, fault, retry_count, loss_count};
  endfunction

  task automatic fill(input int a, input int b, input logic lk, input logic rs,
                      input logic rb, input logic cr, input logic rd,
                      input logic ft, input logic [2:0] rt, input logic [7:0] ls);
    for (int i = a; i <= b; i++) begin
      tbl[i].lock    = lk;
      tbl[i].restart = rs;
      tbl[i].exp     = {rb, cr, rd, ft, rt, ls};
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end else begin
      $display("ok   %s value=%0h", name, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int cyc;

    //   rows     lock rst  rb cr rd ft retry loss
    fill(  1,   3, 0, 0,  0, 0, 0, 0, 3'd0, 8'd0);  // HOLD after reset
    fill(  4,   9, 0, 0,  1, 0, 0, 0, 3'd0, 8'd0);  // WAIT_LOCK
    fill( 10,  19, 1, 0,  1, 0, 0, 0, 3'd0, 8'd0);  // sync + qualify
    fill( 20,  22, 1, 0,  1, 1, 1, 0, 3'd0, 8'd0);  // RUN
    fill( 23,  24, 0, 0,  1, 1, 1, 0, 3'd0, 8'd0);  // loss in flight
    fill( 25,  28, 0, 0,  0, 0, 0, 0, 3'd0, 8'd1);  // HOLD after loss
    fill( 29,  29, 0, 0,  1, 0, 0, 0, 3'd0, 8'd1);
    fill( 30,  39, 1, 0,  1, 0, 0, 0, 3'd0, 8'd1);
    fill( 40,  40, 1, 0,  1, 1, 1, 0, 3'd0, 8'd1);  // RUN again
    fill( 41,  41, 1, 1,  0, 0, 0, 0, 3'd0, 8'd1);  // restart in RUN
    fill( 42,  44, 1, 0,  0, 0, 0, 0, 3'd0, 8'd1);
    fill( 45,  47, 1, 0,  1, 0, 0, 0, 3'd0, 8'd1);  // WAIT, STABLE
    fill( 48,  50, 0, 0,  1, 0, 0, 0, 3'd0, 8'd1);  // 3-cycle glitch
    fill( 51,  60, 1, 0,  1, 0, 0, 0, 3'd0, 8'd1);  // full requalification
    fill( 61,  61, 1, 0,  1, 1, 1, 0, 3'd0, 8'd1);
    fill( 62,  63, 0, 0,  1, 1, 1, 0, 3'd0, 8'd1);
    fill( 64,  67, 0, 0,  0, 0, 0, 0, 3'd0, 8'd2);
    fill( 68,  99, 0, 0,  1, 0, 0, 0, 3'd0, 8'd2);  // first 32-cycle wait
    fill(100, 103, 0, 0,  0, 0, 0, 0, 3'd1, 8'd2);
    fill(104, 135, 0, 0,  1, 0, 0, 0, 3'd1, 8'd2);  // second wait
    fill(136, 139, 0, 0,  0, 0, 0, 1, 3'd2, 8'd2);  // FAULT
    fill(140, 140, 0, 1,  0, 0, 0, 0, 3'd0, 8'd2);  // restart in FAULT
    fill(141, 143, 0, 0,  0, 0, 0, 0, 3'd0, 8'd2);
    fill(144, 145, 0, 0,  1, 0, 0, 0, 3'd0, 8'd2);

    reset_n  = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", 32'(outs_now()), 32'h0);
    reset_n = 1'b1;

    for (int i = 1; i <= NVEC; i++) begin
      pll_lock = tbl[i].lock;
      restart  = tbl[i].restart;
      tick();
      check($sformatf("vec%0d", i), 32'(outs_now()), 32'(tbl[i].exp));
    end

    // Reach STABLE, then assert reset between edges.
    restart  = 1'b0;
    pll_lock = 1'b1;
    repeat (3) tick();
    check("stable_before_async_reset", 32'(outs_now()), 32'h4002);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_immediate", 32'(outs_now()), 32'h0);
    @(posedge clk);
    #2;
    pll_lock = 1'b0;
    reset_n  = 1'b1;

    // Lock becomes visible on the same cycle the timeout expires.
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (k == 3)  check("hold_last_cycle", 32'(outs_now()), 32'h0);
      if (k == 4)  check("hold_release", 32'(outs_now()), 32'h4000);
      if (k == 36) check("lock_beats_timeout", 32'(outs_now()), 32'h4000);
      if (k == 33) pll_lock = 1'b1;
    end
    check("no_retry_after_race_plus1", 32'(outs_now()), 32'h4000);

    cyc = 0;
    while (!ready && cyc < 50) begin
      tick();
      cyc++;
    end
    check("cycles_to_run_after_race", 32'(cyc), 32'd8);
    check("run_outputs", 32'(outs_now()), 32'h7000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
